// File: rtl/exu_result_stage.sv
// Execute-stage result register: W-op sign extension, branch redirect, 2-entry EX/MEM skid buffer.
// Optional EXU_PERF_CNT_EN adds taken-branch and downstream-stall counters.
module exu_result_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   alu_out_i,
    input  logic              compare_out_i,
    input  logic              is_word_i,
    input  logic              is_branch_i,
    input  logic [XLEN-1:0]   br_target_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              rd_wen_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_pc_o,
    output logic [XLEN-1:0]   out_result_o,
    output logic [REG_AW-1:0] out_rd_addr_o,
    output logic              out_rd_wen_o,
`ifdef EXU_PERF_CNT_EN
    output logic [63:0]       perf_br_taken_o,
    output logic [63:0]       perf_stall_o,
`endif
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    logic              r_main_valid;
    logic [XLEN-1:0]   r_main_pc;
    logic [XLEN-1:0]   r_main_result;
    logic [REG_AW-1:0] r_main_rd;
    logic              r_main_wen;

    logic              r_skid_valid;
    logic [XLEN-1:0]   r_skid_pc;
    logic [XLEN-1:0]   r_skid_result;
    logic [REG_AW-1:0] r_skid_rd;
    logic              r_skid_wen;

    logic              r_redir_valid;
    logic [XLEN-1:0]   r_redir_pc;

    logic [XLEN-1:0]   w_result;
    logic              w_wen;
    logic              w_accept;
    logic              w_drain;
    logic              w_taken;

    assign w_result = is_word_i ? {{(XLEN-32){alu_out_i[31]}}, alu_out_i[31:0]}
                                : alu_out_i;
    assign w_wen    = rd_wen_i & ~is_branch_i & (rd_addr_i != '0);
    assign w_accept = in_valid_i & ~r_skid_valid & ~flush_i;
    assign w_drain  = r_main_valid & out_ready_i;
    assign w_taken  = w_accept & is_branch_i & compare_out_i;

    // Ready comes only from SKID occupancy so it never sees out_ready_i.
    assign in_ready_o       = ~r_skid_valid;
    assign out_valid_o      = r_main_valid;
    assign out_pc_o         = r_main_pc;
    assign out_result_o     = r_main_result;
    assign out_rd_addr_o    = r_main_rd;
    assign out_rd_wen_o     = r_main_wen;
    assign redirect_valid_o = r_redir_valid;
    assign redirect_pc_o    = r_redir_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid  <= 1'b0;
            r_main_pc     <= '0;
            r_main_result <= '0;
            r_main_rd     <= '0;
            r_main_wen    <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_pc     <= '0;
            r_skid_result <= '0;
            r_skid_rd     <= '0;
            r_skid_wen    <= 1'b0;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_drain) begin
            if (r_skid_valid) begin
                r_main_valid  <= 1'b1;
                r_main_pc     <= r_skid_pc;
                r_main_result <= r_skid_result;
                r_main_rd     <= r_skid_rd;
                r_main_wen    <= r_skid_wen;
                r_skid_valid  <= 1'b0;
            end else if (w_accept) begin
                r_main_valid  <= 1'b1;
                r_main_pc     <= pc_i;
                r_main_result <= w_result;
                r_main_rd     <= rd_addr_i;
                r_main_wen    <= w_wen;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid  <= 1'b1;
            r_skid_pc     <= pc_i;
            r_skid_result <= w_result;
            r_skid_rd     <= rd_addr_i;
            r_skid_wen    <= w_wen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else begin
            r_redir_valid <= w_taken;
            if (w_taken) begin
                r_redir_pc <= br_target_i;
            end
        end
    end

`ifdef EXU_PERF_CNT_EN
    logic [63:0] r_perf_br;
    logic [63:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_br    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_redir_valid) begin
                r_perf_br <= r_perf_br + 64'd1;
            end
            if (r_main_valid && !out_ready_i) begin
                r_perf_stall <= r_perf_stall + 64'd1;
            end
        end
    end

    assign perf_br_taken_o = r_perf_br;
    assign perf_stall_o    = r_perf_stall;
`endif

endmodule

// File: tb/tb_exu_result_stage.sv
// Directed self-checking bench for exu_result_stage.
// Perf counter checks run when EXU_PERF_CNT_EN is defined.
module tb_exu_result_stage;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] pc_i;
    logic [63:0] alu_out_i;
    logic        compare_out_i;
    logic        is_word_i;
    logic        is_branch_i;
    logic [63:0] br_target_i;
    logic [4:0]  rd_addr_i;
    logic        rd_wen_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_pc_o;
    logic [63:0] out_result_o;
    logic [4:0]  out_rd_addr_o;
    logic        out_rd_wen_o;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;
`ifdef EXU_PERF_CNT_EN
    logic [63:0] perf_br_taken_o;
    logic [63:0] perf_stall_o;
`endif

    int passed;
    int total;

    exu_result_stage #(.XLEN(64), .REG_AW(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .pc_i             (pc_i),
        .alu_out_i        (alu_out_i),
        .compare_out_i    (compare_out_i),
        .is_word_i        (is_word_i),
        .is_branch_i      (is_branch_i),
        .br_target_i      (br_target_i),
        .rd_addr_i        (rd_addr_i),
        .rd_wen_i         (rd_wen_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_pc_o         (out_pc_o),
        .out_result_o     (out_result_o),
        .out_rd_addr_o    (out_rd_addr_o),
        .out_rd_wen_o     (out_rd_wen_o),
`ifdef EXU_PERF_CNT_EN
        .perf_br_taken_o  (perf_br_taken_o),
        .perf_stall_o     (perf_stall_o),
`endif
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid_i    = 1'b0;
        flush_i       = 1'b0;
        pc_i          = '0;
        alu_out_i     = '0;
        compare_out_i = 1'b0;
        is_word_i     = 1'b0;
        is_branch_i   = 1'b0;
        br_target_i   = '0;
        rd_addr_i     = '0;
        rd_wen_i      = 1'b0;
    endtask

    task automatic put_alu(input logic [63:0] pc, input logic [63:0] alu,
                           input logic w, input logic [4:0] rd, input logic wen);
        idle_in();
        in_valid_i = 1'b1;
        pc_i       = pc;
        alu_out_i  = alu;
        is_word_i  = w;
        rd_addr_i  = rd;
        rd_wen_i   = wen;
    endtask

    task automatic put_br(input logic [63:0] pc, input logic [63:0] tgt,
                          input logic cmp);
        idle_in();
        in_valid_i    = 1'b1;
        pc_i          = pc;
        is_branch_i   = 1'b1;
        compare_out_i = cmp;
        br_target_i   = tgt;
        rd_addr_i     = 5'd3;
        rd_wen_i      = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        out_ready_i = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        out_ready_i = 1'b0;
        #3;
        total++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || redirect_valid_o !== 1'b0)
            $display("FAIL reset_ctrl: got v=%b rdy=%b redir=%b, expected 0/1/0",
                     out_valid_o, in_ready_o, redirect_valid_o);
        else passed++;
        total++;
        if (out_result_o !== 64'd0 || out_pc_o !== 64'd0 || out_rd_wen_o !== 1'b0 ||
            out_rd_addr_o !== 5'd0 || redirect_pc_o !== 64'd0)
            $display("FAIL reset_data: got res=%h pc=%h wen=%b rd=%0d rpc=%h, expected 0s",
                     out_result_o, out_pc_o, out_rd_wen_o, out_rd_addr_o, redirect_pc_o);
        else passed++;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_wext();
        out_ready_i = 1'b1;
        put_alu(64'h1000, 64'h0000_0000_8000_0001, 1'b1, 5'd5, 1'b1);
        step();
        idle_in();
        total++;
        if (out_valid_o !== 1'b1 || out_result_o !== 64'hFFFF_FFFF_8000_0001 ||
            out_rd_wen_o !== 1'b1 || out_rd_addr_o !== 5'd5 || out_pc_o !== 64'h1000)
            $display("FAIL wext: got v=%b res=%h wen=%b rd=%0d pc=%h, expected 1/ffffffff80000001/1/5/1000",
                     out_valid_o, out_result_o, out_rd_wen_o, out_rd_addr_o, out_pc_o);
        else passed++;
        put_alu(64'h1004, 64'h1234_5678_0000_7FFF, 1'b0, 5'd7, 1'b1);
        step();
        idle_in();
        total++;
        if (out_result_o !== 64'h1234_5678_0000_7FFF || out_rd_wen_o !== 1'b1)
            $display("FAIL no_wext: got res=%h wen=%b, expected 1234567800007fff/1",
                     out_result_o, out_rd_wen_o);
        else passed++;
        step();
        total++;
        if (out_valid_o !== 1'b0)
            $display("FAIL drain_empty: got v=%b, expected 0", out_valid_o);
        else passed++;
    endtask

    task automatic test_x0_branch();
        out_ready_i = 1'b1;
        put_alu(64'h2000, 64'h55, 1'b0, 5'd0, 1'b1);
        step();
        idle_in();
        total++;
        if (out_valid_o !== 1'b1 || out_rd_wen_o !== 1'b0)
            $display("FAIL x0_wen: got v=%b wen=%b, expected 1/0", out_valid_o, out_rd_wen_o);
        else passed++;
        put_br(64'h2004, 64'h8000_0100, 1'b1);
        step();
        idle_in();
        total++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'h8000_0100)
            $display("FAIL br_taken: got redir=%b rpc=%h, expected 1/80000100",
                     redirect_valid_o, redirect_pc_o);
        else passed++;
        total++;
        if (out_valid_o !== 1'b1 || out_rd_wen_o !== 1'b0 || out_pc_o !== 64'h2004)
            $display("FAIL br_flow: got v=%b wen=%b pc=%h, expected 1/0/2004",
                     out_valid_o, out_rd_wen_o, out_pc_o);
        else passed++;
        step();
        total++;
        if (redirect_valid_o !== 1'b0)
            $display("FAIL br_pulse_len: got redir=%b, expected 0", redirect_valid_o);
        else passed++;
        put_br(64'h2008, 64'h8000_0100, 1'b0);
        step();
        idle_in();
        total++;
        if (redirect_valid_o !== 1'b0 || out_valid_o !== 1'b1)
            $display("FAIL br_not_taken: got redir=%b v=%b, expected 0/1",
                     redirect_valid_o, out_valid_o);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        put_br(64'h3000, 64'hA000, 1'b1);
        step();
        put_br(64'h3004, 64'hB000, 1'b1);
        total++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'hA000)
            $display("FAIL b2b_first: got redir=%b rpc=%h, expected 1/a000",
                     redirect_valid_o, redirect_pc_o);
        else passed++;
        step();
        idle_in();
        total++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'hB000)
            $display("FAIL b2b_second: got redir=%b rpc=%h, expected 1/b000",
                     redirect_valid_o, redirect_pc_o);
        else passed++;
        step();
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        put_alu(64'h4000, 64'hAAAA, 1'b0, 5'd1, 1'b1);
        step();
        total++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b1 || out_result_o !== 64'hAAAA)
            $display("FAIL bp_a: got rdy=%b v=%b res=%h, expected 1/1/aaaa",
                     in_ready_o, out_valid_o, out_result_o);
        else passed++;
        put_alu(64'h4004, 64'hBBBB, 1'b0, 5'd2, 1'b1);
        step();
        idle_in();
        total++;
        if (in_ready_o !== 1'b0 || out_result_o !== 64'hAAAA || out_pc_o !== 64'h4000)
            $display("FAIL bp_full: got rdy=%b res=%h pc=%h, expected 0/aaaa/4000",
                     in_ready_o, out_result_o, out_pc_o);
        else passed++;
        step();
        total++;
        if (out_valid_o !== 1'b1 || out_result_o !== 64'hAAAA || out_rd_addr_o !== 5'd1)
            $display("FAIL bp_hold: got v=%b res=%h rd=%0d, expected 1/aaaa/1",
                     out_valid_o, out_result_o, out_rd_addr_o);
        else passed++;
        out_ready_i = 1'b1;
        step();
        total++;
        if (out_valid_o !== 1'b1 || out_result_o !== 64'hBBBB || in_ready_o !== 1'b1 ||
            out_rd_addr_o !== 5'd2)
            $display("FAIL bp_b: got v=%b res=%h rdy=%b rd=%0d, expected 1/bbbb/1/2",
                     out_valid_o, out_result_o, in_ready_o, out_rd_addr_o);
        else passed++;
        step();
        total++;
        if (out_valid_o !== 1'b0)
            $display("FAIL bp_empty: got v=%b, expected 0", out_valid_o);
        else passed++;
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        put_alu(64'h5000, 64'h11, 1'b0, 5'd4, 1'b1);
        step();
        put_alu(64'h5004, 64'h22, 1'b0, 5'd4, 1'b1);
        step();
        put_br(64'h5008, 64'hC000, 1'b1);
        flush_i = 1'b1;
        step();
        idle_in();
        total++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || redirect_valid_o !== 1'b0)
            $display("FAIL flush_full: got v=%b rdy=%b redir=%b, expected 0/1/0",
                     out_valid_o, in_ready_o, redirect_valid_o);
        else passed++;
        put_br(64'h500C, 64'hD000, 1'b1);
        flush_i = 1'b1;
        step();
        idle_in();
        total++;
        if (out_valid_o !== 1'b0 || redirect_valid_o !== 1'b0)
            $display("FAIL flush_empty: got v=%b redir=%b, expected 0/0",
                     out_valid_o, redirect_valid_o);
        else passed++;
        out_ready_i = 1'b1;
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        put_alu(64'h6000, 64'h77, 1'b0, 5'd9, 1'b1);
        step();
        put_br(64'h6004, 64'hE000, 1'b1);
        step();
        idle_in();
        total++;
        if (redirect_valid_o !== 1'b1 || in_ready_o !== 1'b0)
            $display("FAIL ar_pre: got redir=%b rdy=%b, expected 1/0",
                     redirect_valid_o, in_ready_o);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid_o !== 1'b0 || redirect_valid_o !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL async_reset: got v=%b redir=%b rdy=%b, expected 0/0/1",
                     out_valid_o, redirect_valid_o, in_ready_o);
        else passed++;
        step();
        rst = 1'b0;
        out_ready_i = 1'b1;
        #1;
    endtask

`ifdef EXU_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        total++;
        if (perf_br_taken_o !== 64'd0 || perf_stall_o !== 64'd0)
            $display("FAIL perf_reset: got br=%0d st=%0d, expected 0/0",
                     perf_br_taken_o, perf_stall_o);
        else passed++;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put_br(64'h7000 + 64'(i * 4), 64'hF000, 1'b1);
            step();
        end
        idle_in();
        step();
        step();
        out_ready_i = 1'b0;
        put_alu(64'h7100, 64'h1, 1'b0, 5'd1, 1'b1);
        step();
        idle_in();
        for (int i = 0; i < 4; i++) step();
        out_ready_i = 1'b1;
        step();
        step();
        total++;
        if (perf_br_taken_o !== 64'd3 || perf_stall_o !== 64'd4)
            $display("FAIL perf_counts: got br=%0d st=%0d, expected 3/4",
                     perf_br_taken_o, perf_stall_o);
        else passed++;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_wext();
        test_x0_branch();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef EXU_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/exu_result_stage.md
Name: exu_result_stage

Overview:
- Execute-stage result register directly downstream of the combinational ALU.
- Takes the ALU result and compare flag, applies the RV64 W-op sign extension, and resolves conditional branches into a one-cycle redirect pulse.
- Registers the writeback payload into a 2-entry EX/MEM skid buffer with valid/ready handshakes on both sides.

Parameters:
- XLEN, 64, datapath width.
- REG_AW, 5, register-file index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  pipeline flush; kills buffered and incoming ops.
- in_valid_i  in  1  upstream op valid.
- in_ready_o  out  1  stage can accept an op.
- pc_i  in  XLEN  op PC.
- alu_out_i  in  XLEN  ALU result.
- compare_out_i  in  1  ALU compare flag.
- is_word_i  in  1  W-op; sign-extend result bit 31.
- is_branch_i  in  1  conditional branch op.
- br_target_i  in  XLEN  branch target address.
- rd_addr_i  in  REG_AW  destination register.
- rd_wen_i  in  1  destination write enable.
- out_valid_o  out  1  downstream payload valid.
- out_ready_i  in  1  downstream accepts.
- out_pc_o  out  XLEN  PC of output op.
- out_result_o  out  XLEN  final result.
- out_rd_addr_o  out  REG_AW  destination register.
- out_rd_wen_o  out  1  effective write enable.
- redirect_valid_o  out  1  taken-branch redirect pulse.
- redirect_pc_o  out  XLEN  redirect target.

Behaviour:
- Reset: all outputs 0 except in_ready_o = 1. Both buffer entries invalid.
- Result formation (combinational, at input):
  - is_word_i = 1: result = {32{alu_out_i[31]}, alu_out_i[31:0]}.
  - otherwise: result = alu_out_i.
- Write-enable formation: wen = rd_wen_i & ~is_branch_i & (rd_addr_i != 0).
- Accept: in_valid_i & in_ready_o & ~flush_i.
- Buffer entries: MAIN (drives outputs) and SKID.
  - in_ready_o = ~skid_valid, registered. It never depends combinationally on out_ready_i.
- Per cycle, without flush:
  - Drain: out_valid_o & out_ready_i.
  - If MAIN is empty or draining: MAIN loads from SKID when SKID is valid (SKID clears), else from the accepted input, else MAIN goes invalid.
  - If MAIN holds and does not drain: an accepted input goes to SKID.
- Ordering: ops leave strictly in acceptance order. Latency from accept to out_valid_o is 1 cycle when unstalled.
- Outputs are stable while out_valid_o = 1 and out_ready_i = 0.
- Redirect:
  - Condition: accepted op with is_branch_i & compare_out_i.
  - Next cycle: redirect_valid_o = 1 for exactly one cycle, redirect_pc_o = br_target_i.
  - Not-taken branches produce no pulse.
  - The redirect does not depend on downstream stall.
  - The branch op still flows to the output with wen = 0.
- Flush:
  - Next edge: MAIN and SKID invalid, in_ready_o = 1, redirect_valid_o = 0.
  - The input presented in the flush cycle is dropped and does not redirect.
  - Flush takes priority over drain and accept in the same cycle.
- Back-to-back taken branches in consecutive accepts give consecutive pulses, each carrying its own target.
- Reset asserted mid-operation clears all state immediately.

Optional Feature:
- Macro: EXU_PERF_CNT_EN.
- When defined:
  - Adds two 64-bit counters, output ports perf_br_taken_o and perf_stall_o, both resetting to 0.
  - perf_br_taken_o increments on each redirect pulse.
  - perf_stall_o increments each cycle with out_valid_o & ~out_ready_i.
  - Counters are not cleared by flush and wrap at 2^64.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- W sign extension: alu_out_i = 0x0000_0000_8000_0001, is_word_i = 1, rd = 5, out_ready_i = 1 -> next cycle out_result_o = 0xFFFF_FFFF_8000_0001, out_rd_wen_o = 1.
- x0 write and taken branch:
  - rd_addr_i = 0, rd_wen_i = 1 -> out_rd_wen_o = 0.
  - is_branch_i = 1, compare_out_i = 1, br_target_i = 0x8000_0100 -> redirect_valid_o = 1 for one cycle with redirect_pc_o = 0x8000_0100.
  - Same op with compare_out_i = 0 -> no pulse.
- Backpressure: out_ready_i = 0, send ops A and B -> in_ready_o falls after B; outputs hold A. Raise out_ready_i -> A then B emerge in order, and in_ready_o returns to 1.
- Flush: with MAIN and SKID full, assert flush_i together with in_valid_i carrying a taken branch -> next cycle out_valid_o = 0, in_ready_o = 1, no redirect pulse.
- Async reset: assert rst mid-stall between clock edges -> out_valid_o and redirect_valid_o drop immediately, and in_ready_o = 1.
- Perf counters (EXU_PERF_CNT_EN defined): 3 taken branches and 4 stall cycles -> perf_br_taken_o = 3, perf_stall_o = 4.
